// File: rtl/lenet_pkg.sv
// lenet_pkg: bank/compute state types and frame geometry shared by the frame scheduler.
`ifndef WD
`define WD 15
`endif
package lenet_pkg;
  localparam int NPIX = 1024;
  localparam int AW = 10;
  localparam int QA_W = `WD + 1;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_BUSY} bank_st_t;
  typedef enum logic [1:0] {C_IDLE, C_GO, C_WAIT, C_OUT} cmp_st_t;
  function automatic logic can_fill(input bank_st_t s);
    return s == B_EMPTY || s == B_FILLING;
  endfunction
endpackage

// File: rtl/frame_bank.sv
// frame_bank: one frame of pixels, single write port and a registered read port that holds when idle.
module frame_bank #(
  parameter int PIX_W = 8,
  parameter int NPIX = 1024,
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [PIX_W-1:0] wd_i,
  input  logic             re_i,
  input  logic [AW-1:0]    ra_i,
  output logic [PIX_W-1:0] rd_o
);
  logic [PIX_W-1:0] mem_q [NPIX];
  always_ff @(posedge clk) if (we_i) mem_q[wa_i] <= wd_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_o <= '0;
    else if (re_i) rd_o <= mem_q[ra_i];
endmodule

// File: rtl/lenet_frame_sched.sv
// lenet_frame_sched: ping-pong frame buffer that fills one bank while lenet classifies the other,
// sequencing go/ready and returning each digit tagged with its frame index.
module lenet_frame_sched import lenet_pkg::*; #(
  parameter int PIX_W = 8,
  parameter int NPIX = lenet_pkg::NPIX,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              go,
  input  logic              ready,
  input  logic [3:0]        digit,
  input  logic              cena_src,
  input  logic [AW-1:0]     aa_src,
  output logic [QA_W-1:0]   qa_src,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_digit,
  output logic [FCNT_W-1:0] res_frame,
  output logic              busy
);
  bank_st_t bs_q [2];
  bank_st_t bs_d [2];
  cmp_st_t cs_q, cs_d;
  logic wb_q, wb_d, rb_q, rb_d, sel_q, pix_ready_d, busy_d, acc, last;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d, res_frame_d;
  logic [3:0] res_digit_d;
  logic [PIX_W-1:0] rd [2];
  assign acc = pix_valid & pix_ready;
  assign last = wcnt_q == AW'(NPIX - 1);
  assign go = cs_q == C_GO;
  assign res_valid = cs_q == C_OUT;
  assign qa_src = QA_W'(rd[sel_q]);
  for (genvar i = 0; i < 2; i++) begin : g_bank
    frame_bank #(.PIX_W(PIX_W), .NPIX(NPIX), .AW(AW)) u_bank (
      .clk  (clk),
      .rst  (rstn),
      .we_i (acc && wb_q == 1'(i)),
      .wa_i (wcnt_q),
      .wd_i (pix_data),
      .re_i (!cena_src),
      .ra_i (aa_src),
      .rd_o (rd[i])
    );
  end
  // Loader and compute touch different banks, so both updates may land in one cycle.
  always_comb begin
    bs_d = bs_q;
    cs_d = cs_q;
    wb_d = wb_q;
    rb_d = rb_q;
    wcnt_d = wcnt_q;
    fcnt_d = fcnt_q;
    res_digit_d = res_digit;
    res_frame_d = res_frame;
    if (acc) begin
      bs_d[wb_q] = last ? B_FULL : B_FILLING;
      wcnt_d = last ? '0 : wcnt_q + AW'(1);
      wb_d = wb_q ^ last;
    end
    case (cs_q)
      C_IDLE: if (bs_q[rb_q] == B_FULL) begin
        bs_d[rb_q] = B_BUSY;
        cs_d = C_GO;
      end
      C_GO: cs_d = C_WAIT;
      C_WAIT: if (ready) begin
        res_digit_d = digit;
        res_frame_d = fcnt_q;
        cs_d = C_OUT;
      end
      C_OUT: if (res_ready) begin
        bs_d[rb_q] = B_EMPTY;
        rb_d = !rb_q;
        fcnt_d = fcnt_q + FCNT_W'(1);
        cs_d = C_IDLE;
      end
      default: cs_d = C_IDLE;
    endcase
    pix_ready_d = can_fill(bs_d[wb_d]);
    busy_d = bs_d[0] != B_EMPTY || bs_d[1] != B_EMPTY;
  end
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      bs_q <= '{B_EMPTY, B_EMPTY};
      cs_q <= C_IDLE;
      wb_q <= 1'b0;
      rb_q <= 1'b0;
      sel_q <= 1'b0;
      wcnt_q <= '0;
      fcnt_q <= '0;
      res_digit <= '0;
      res_frame <= '0;
      pix_ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      bs_q <= bs_d;
      cs_q <= cs_d;
      wb_q <= wb_d;
      rb_q <= rb_d;
      sel_q <= cena_src ? sel_q : rb_q;
      wcnt_q <= wcnt_d;
      fcnt_q <= fcnt_d;
      res_digit <= res_digit_d;
      res_frame <= res_frame_d;
      pix_ready <= pix_ready_d;
      busy <= busy_d;
    end
endmodule

// File: tb/tb_lenet_frame_sched.sv
// tb_lenet_frame_sched: streams frames into the scheduler, models lenet reads/results, scoreboards digits and frame indices.
`ifndef WD
`define WD 15
`endif
module tb_lenet_frame_sched;
  localparam int NP = 1024;
  logic clk = 0, rstn = 1;
  logic pix_valid = 0, ready = 0, cena_src = 1, res_ready = 1;
  logic [7:0] pix_data = 0;
  logic [3:0] digit = 0;
  logic [9:0] aa_src = 0;
  logic pix_ready, go, res_valid, busy;
  logic [`WD:0] qa_src;
  logic [3:0] res_digit;
  logic [15:0] res_frame;
  typedef struct { int seed; logic [3:0] dig; int lat; } job_t;
  typedef struct { logic [3:0] dig; logic [15:0] frame; } res_t;
  typedef struct { int seed; logic [3:0] dig; int lat; bit gappy; } vec_t;
  job_t dq[$];
  res_t exp_q[$];
  res_t rr;
  vec_t vt [4];
  int nchk = 0, nerr = 0, cyc = 0, go_cnt = 0, go_cyc = 0;
  logic [15:0] nxt_frame = 0;
  bit spur_req = 0;

  lenet_frame_sched dut (
    .clk(clk), .rstn(rstn), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .go(go), .ready(ready), .digit(digit), .cena_src(cena_src), .aa_src(aa_src), .qa_src(qa_src),
    .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit), .res_frame(res_frame), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (go) begin go_cnt++; go_cyc = cyc; end

  task automatic chk(input string nm, input longint act, input longint req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] pix(input int seed, input int a);
    return a == 296 ? 8'(84 + seed) : 8'(a * 5 + seed * 17);
  endfunction

  // lenet model: on go, reads the frame back through the source port, then reports its digit
  initial begin : lenet_model
    job_t j;
    forever begin
      @(negedge clk);
      if (spur_req) begin
        ready = 1; digit = 4'd9;
        @(negedge clk);
        ready = 0; spur_req = 0;
      end else if (go) begin
        if (dq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_go at cycle %0d", cyc);
        end else begin
          j = dq.pop_front();
          cena_src = 0; aa_src = 10'd296;
          @(negedge clk);
          chk("qa_296", qa_src, pix(j.seed, 296));
          aa_src = 10'd0;
          @(negedge clk);
          chk("qa_0", qa_src, pix(j.seed, 0));
          cena_src = 1; aa_src = 10'd1023;
          @(negedge clk);
          chk("qa_hold", qa_src, pix(j.seed, 0));
          repeat (j.lat) @(negedge clk);
          ready = 1; digit = j.dig;
          @(negedge clk);
          ready = 0;
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (!rstn && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_result: digit %0d frame %0d", res_digit, res_frame);
      end else begin
        rr = exp_q.pop_front();
        chk("res_digit", res_digit, rr.dig);
        chk("res_frame", res_frame, rr.frame);
      end
    end
  end

  task automatic stream(input int seed, input int n, input bit gappy, input logic [3:0] dig,
                        input int lat, output int t_last, output int stalls);
    int i = 0, budget = 0;
    bit ph = 0;
    stalls = 0; t_last = 0;
    while (i < n && budget < 20000) begin
      @(negedge clk);
      budget++;
      if (gappy && ph) pix_valid = 0;
      else begin
        pix_valid = 1;
        pix_data = pix(seed, i);
        if (pix_ready) begin
          if (i == n - 1) t_last = cyc;
          i++;
        end else stalls++;
      end
      ph = !ph;
    end
    @(negedge clk);
    pix_valid = 0;
    if (i < n) begin
      nchk++; nerr++;
      $display("FAIL stream_timeout: accepted %0d of %0d", i, n);
    end
    if (n == NP) begin
      dq.push_back('{seed, dig, lat});
      exp_q.push_back('{dig, nxt_frame});
      nxt_frame++;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || dq.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || dq.size() != 0 || busy) begin
      nchk++; nerr++;
      $display("FAIL wait_done_timeout: pending results %0d busy %0d", exp_q.size(), busy);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, st, g0, n;
    vt[0] = '{0, 4'd7, 30, 1'b0};
    vt[1] = '{1, 4'd3, 5, 1'b1};
    vt[2] = '{2, 4'd0, 60, 1'b0};
    vt[3] = '{6, 4'd9, 12, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_go", go, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_digit", res_digit, 0);
    chk("rst_res_frame", res_frame, 0);
    chk("rst_qa_src", qa_src, 0);
    chk("rst_busy", busy, 0);
    rstn = 0;
    @(negedge clk);
    chk("pix_ready_rise", pix_ready, 1);
    chk("idle_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      g0 = go_cnt;
      stream(vt[k].seed, NP, vt[k].gappy, vt[k].dig, vt[k].lat, t, st);
      chk("fill_busy", busy, 1);
      chk("vec_no_stall", st, 0);
      wait_done(5000);
      chk("vec_go_count", go_cnt - g0, 1);
      chk("vec_go_delay", go_cyc - t, 2);
    end
    // overlap: frame 1 fills during frame 0 compute, frame 2 must wait for a free bank
    stream(3, NP, 0, 4'd4, 1500, t, st);
    stream(4, NP, 0, 4'd5, 1500, t, st);
    chk("overlap_no_stall", st, 0);
    stream(5, NP, 0, 4'd6, 1500, t, st);
    chk("third_frame_stalled", longint'(st > 0), 1);
    wait_done(8000);
    // backpressure: result held while the other bank waits FULL
    res_ready = 0;
    stream(10, NP, 0, 4'd8, 10, t, st);
    stream(11, NP, 0, 4'd1, 10, t, st);
    n = 0;
    while (!res_valid && n < 500) begin @(negedge clk); n++; end
    chk("bp_res_valid_seen", res_valid, 1);
    g0 = go_cnt;
    repeat (50) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_digit", res_digit, exp_q[0].dig);
      chk("bp_frame", res_frame, exp_q[0].frame);
    end
    chk("bp_no_go", go_cnt - g0, 0);
    chk("bp_busy", busy, 1);
    res_ready = 1;
    wait_done(5000);
    // spurious ready while idle must be ignored
    g0 = go_cnt;
    spur_req = 1;
    repeat (10) @(negedge clk);
    chk("spur_no_result", res_valid, 0);
    chk("spur_no_go", go_cnt - g0, 0);
    // frame counter wrap
    force dut.fcnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.fcnt_q;
    nxt_frame = 16'hFFFF;
    stream(12, NP, 0, 4'd5, 20, t, st);
    stream(13, NP, 0, 4'd2, 20, t, st);
    wait_done(5000);
    // reset mid-fill discards the partial frame
    stream(20, 500, 0, 4'd0, 0, t, st);
    rstn = 1;
    repeat (2) @(negedge clk);
    chk("midrst_pix_ready", pix_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    rstn = 0;
    nxt_frame = 0;
    g0 = go_cnt;
    stream(21, NP, 0, 4'd2, 20, t, st);
    wait_done(5000);
    chk("midrst_go_once", go_cnt - g0, 1);
    chk("midrst_go_delay", go_cyc - t, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
